// File: rtl/rr_aligner_pkg.sv
// Shared types and defaults for the packed logging-bus aligner.
package rr_aligner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } aligner_state_e;

  localparam int DEF_IN_WIDTH     = 512;
  localparam int DEF_OUT_WIDTH    = 512;
  localparam int DEF_FIFO_DEPTH   = 32;
  localparam int DEF_ALMFUL_SLACK = 8;

  // Width needed to express a bit length 0..in_width inclusive.
  function automatic int calc_in_len_w(input int in_width);
    return $clog2(in_width + 1);
  endfunction

endpackage

// File: rtl/rr_beat_fifo.sv
// First-word-fall-through beat FIFO; a count register separates full from empty.
module rr_beat_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));

  // Next pointer/count; a pop frees a slot so a push into a full FIFO is legal then.
  always_comb begin
    do_pop   = pop && head_valid;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rr_packed_logb_aligner.sv
// Packs variable-length logging records bit-contiguously into fixed-width
// beats, buffers them in a FWFT FIFO, and supports a pad-and-drain flush.
module rr_packed_logb_aligner
  import rr_aligner_pkg::*;
#(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int ALMFUL_SLACK = DEF_ALMFUL_SLACK,
  parameter int IN_LEN_W     = calc_in_len_w(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_any_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [IN_LEN_W-1:0]  in_len,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic                 almful,
  output logic                 overflow,
  output logic [63:0]          beat_cnt
);

  localparam int ACC_W  = OUT_WIDTH + IN_WIDTH;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  if (IN_WIDTH > OUT_WIDTH) begin : g_width_check
    $error("rr_packed_logb_aligner: IN_WIDTH must not exceed OUT_WIDTH");
  end
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("rr_packed_logb_aligner: FIFO_DEPTH must be a power of two >= 4");
  end

  aligner_state_e     state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               flush_done_q, flush_done_d;
  logic               almful_q, almful_d;
  logic               overflow_q, overflow_d;
  logic [63:0]        beat_cnt_q, beat_cnt_d;

  logic [IN_WIDTH-1:0]  len_mask;
  logic [IN_WIDTH-1:0]  rec_bits;
  logic [ACC_W-1:0]     keep_mask;
  logic [ACC_W-1:0]     acc_keep;
  logic [ACC_W-1:0]     acc_merge;
  logic [FILL_W-1:0]    fill_sum;
  logic                 rec_live;

  logic                 fifo_push;
  logic [OUT_WIDTH-1:0] fifo_push_data;
  logic                 fifo_pop;
  logic                 fifo_head_valid;
  logic [OUT_WIDTH-1:0] fifo_head_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 can_push;
  logic [CNT_W-1:0]     count_next;

  rr_beat_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (fifo_push),
    .push_data  (fifo_push_data),
    .pop        (fifo_pop),
    .head_valid (fifo_head_valid),
    .head_data  (fifo_head_data),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  assign fifo_pop   = fifo_head_valid && out_ready;
  assign can_push   = !fifo_full || fifo_pop;
  assign out_valid  = fifo_head_valid;
  assign out_data   = fifo_head_data;
  assign flush_done = flush_done_q;
  assign almful     = almful_q;
  assign overflow   = overflow_q;
  assign beat_cnt   = beat_cnt_q;

  // Record alignment: clear bits above in_len and above fill, then merge at fill.
  always_comb begin
    len_mask  = ~({IN_WIDTH{1'b1}} << in_len);
    rec_bits  = in_data & len_mask;
    keep_mask = ~({ACC_W{1'b1}} << fill_q);
    acc_keep  = acc_q & keep_mask;
    acc_merge = acc_keep | (ACC_W'(rec_bits) << fill_q);
    fill_sum  = fill_q + FILL_W'(in_len);
    rec_live  = in_any_valid && (in_len != '0);
  end

  // Accumulator, beat emission and flush sequencing.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    fill_d         = fill_q;
    overflow_d     = overflow_q;
    fifo_push      = 1'b0;
    fifo_push_data = acc_keep[OUT_WIDTH-1:0];
    unique case (state_q)
      IDLE: begin
        if (rec_live) begin
          if (fill_sum >= FILL_W'(OUT_WIDTH)) begin
            // A full beat is ready; residual bits are kept even if the beat is dropped.
            fifo_push_data = acc_merge[OUT_WIDTH-1:0];
            if (can_push) begin
              fifo_push = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            acc_d  = acc_merge >> OUT_WIDTH;
            fill_d = fill_sum - FILL_W'(OUT_WIDTH);
          end else begin
            acc_d  = acc_merge;
            fill_d = fill_sum;
          end
        end
        if (flush) begin
          state_d = PAD;
        end
      end
      PAD: begin
        if (rec_live) begin
          overflow_d = 1'b1;
        end
        if (fill_q == '0) begin
          state_d = DRAIN;
        end else if (can_push) begin
          // Partial beat goes out zero-padded; stall rather than drop when full.
          fifo_push = 1'b1;
          fill_d    = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (rec_live) begin
          overflow_d = 1'b1;
        end
        if (fifo_count == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rec_live) begin
          overflow_d = 1'b1;
        end
        if (!flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered status outputs derived from the next FIFO occupancy and state.
  always_comb begin
    count_next   = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    almful_d     = (FIFO_DEPTH - int'(count_next)) <= ALMFUL_SLACK;
    flush_done_d = (state_d == DONE);
    beat_cnt_d   = beat_cnt_q + 64'(fifo_push);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
      almful_q     <= 1'b0;
      overflow_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      flush_done_q <= flush_done_d;
      almful_q     <= almful_d;
      overflow_q   <= overflow_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Accumulator data; bits at and above fill are masked on use, so no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_rr_packed_logb_aligner.sv
// Directed bench for rr_packed_logb_aligner at 16/16 widths and a 4-deep FIFO.
module tb_rr_packed_logb_aligner;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_any_valid;
  logic [15:0] in_data;
  logic [4:0]  in_len;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        almful;
  logic        overflow;
  logic [63:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  rr_packed_logb_aligner #(
    .IN_WIDTH     (16),
    .OUT_WIDTH    (16),
    .FIFO_DEPTH   (4),
    .ALMFUL_SLACK (1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_any_valid (in_any_valid),
    .in_data      (in_data),
    .in_len       (in_len),
    .flush        (flush),
    .flush_done   (flush_done),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .almful       (almful),
    .overflow     (overflow),
    .beat_cnt     (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] l);
    in_any_valid = 1'b1;
    in_data      = d;
    in_len       = l;
    step();
    in_any_valid = 1'b0;
    in_data      = '0;
    in_len       = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!flush_done && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(flush_done), 64'h1);
  endtask

  initial begin
    logic [15:0] exp3 [4];
    logic [15:0] exp4 [5];
    exp3 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp4 = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h005A};

    rstn         = 1'b0;
    in_any_valid = 1'b0;
    in_data      = '0;
    in_len       = '0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_flush_done", 64'(flush_done), 64'h0);
    chk("rst_almful", 64'(almful), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_beat_cnt", beat_cnt, 64'h0);
    rstn = 1'b1;
    step();

    // Four nibbles pack into one beat.
    out_ready = 1'b1;
    send(16'h0001, 5'd4);
    chk("t1_no_beat_1", 64'(out_valid), 64'h0);
    send(16'h0002, 5'd4);
    send(16'h0003, 5'd4);
    chk("t1_no_beat_3", 64'(out_valid), 64'h0);
    send(16'h0004, 5'd4);
    chk("t1_valid", 64'(out_valid), 64'h1);
    chk("t1_data", 64'(out_data), 64'h4321);
    chk("t1_beat_cnt", beat_cnt, 64'h1);
    step();
    chk("t1_popped", 64'(out_valid), 64'h0);
    chk("t1_beat_cnt_hold", beat_cnt, 64'h1);

    // Straddling record, then flush pads the 4 residual bits.
    do_reset();
    out_ready = 1'b0;
    send(16'h0ABC, 5'd12);
    chk("t2_no_beat", 64'(out_valid), 64'h0);
    send(16'h00DE, 5'd8);
    chk("t2_valid", 64'(out_valid), 64'h1);
    chk("t2_data", 64'(out_data), 64'hEABC);
    out_ready = 1'b1;
    step();
    chk("t2_popped", 64'(out_valid), 64'h0);
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    chk("t2_pad_not_yet", 64'(out_valid), 64'h0);
    step();
    chk("t2_pad_valid", 64'(out_valid), 64'h1);
    chk("t2_pad_data", 64'(out_data), 64'h000D);
    chk("t2_pad_beat_cnt", beat_cnt, 64'h2);
    chk("t2_done_early", 64'(flush_done), 64'h0);
    out_ready = 1'b1;
    wait_done("t2_flush_done");
    chk("t2_empty_at_done", 64'(out_valid), 64'h0);
    flush = 1'b0;
    step();
    chk("t2_done_release", 64'(flush_done), 64'h0);

    // Backpressure: almful, overflow drop, then in-order drain.
    do_reset();
    out_ready = 1'b0;
    send(16'h1111, 5'd16);
    chk("t3_valid", 64'(out_valid), 64'h1);
    chk("t3_almful_1", 64'(almful), 64'h0);
    send(16'h2222, 5'd16);
    chk("t3_almful_2", 64'(almful), 64'h0);
    send(16'h3333, 5'd16);
    chk("t3_almful_3", 64'(almful), 64'h1);
    send(16'h4444, 5'd16);
    chk("t3_no_ovf_4", 64'(overflow), 64'h0);
    chk("t3_beat_cnt_4", beat_cnt, 64'h4);
    send(16'h5555, 5'd16);
    chk("t3_overflow", 64'(overflow), 64'h1);
    chk("t3_beat_cnt_drop", beat_cnt, 64'h4);
    chk("t3_head", 64'(out_data), 64'h1111);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_pop_valid_%0d", k), 64'(out_valid), 64'h1);
      chk($sformatf("t3_pop_data_%0d", k), 64'(out_data), 64'(exp3[k]));
      step();
    end
    chk("t3_drained", 64'(out_valid), 64'h0);
    chk("t3_ovf_sticky", 64'(overflow), 64'h1);

    // Flush against a full FIFO stalls in PAD without dropping.
    do_reset();
    out_ready = 1'b0;
    send(16'h1001, 5'd16);
    send(16'h2002, 5'd16);
    send(16'h3003, 5'd16);
    send(16'h4004, 5'd16);
    send(16'h005A, 5'd8);
    flush = 1'b1;
    step();
    step();
    step();
    chk("t4_stall_head", 64'(out_data), 64'h1001);
    chk("t4_stall_beat_cnt", beat_cnt, 64'h4);
    chk("t4_stall_no_ovf", 64'(overflow), 64'h0);
    chk("t4_stall_not_done", 64'(flush_done), 64'h0);
    send(16'h0007, 5'd0);
    chk("t4_zero_len_pad", 64'(overflow), 64'h0);
    send(16'h000F, 5'd4);
    chk("t4_input_in_pad", 64'(overflow), 64'h1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_pop_valid_%0d", k), 64'(out_valid), 64'h1);
      chk($sformatf("t4_pop_data_%0d", k), 64'(out_data), 64'(exp4[k]));
      step();
    end
    wait_done("t4_flush_done");
    chk("t4_beat_cnt", beat_cnt, 64'h5);
    flush = 1'b0;
    step();

    // Zero-length no-op, idle, masking, then asynchronous reset.
    do_reset();
    out_ready = 1'b0;
    send(16'hFFF3, 5'd4);
    send(16'hFFFF, 5'd0);
    repeat (16) step();
    chk("t5_idle_no_beat", 64'(out_valid), 64'h0);
    chk("t5_idle_no_ovf", 64'(overflow), 64'h0);
    chk("t5_idle_beat_cnt", beat_cnt, 64'h0);
    send(16'h8765, 5'd12);
    chk("t5_valid", 64'(out_valid), 64'h1);
    chk("t5_data", 64'(out_data), 64'h7653);
    send(16'hBEEF, 5'd16);
    chk("t5_beat_cnt", beat_cnt, 64'h2);
    #3;
    rstn = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'h0);
    chk("t5_async_beat_cnt", beat_cnt, 64'h0);
    step();
    rstn = 1'b1;
    step();
    chk("t5_after_rst", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_packed_logb_aligner.md
Name: rr_packed_logb_aligner

Overview:
- Consumes the packed logging-bus stream produced by the merge tree: per-cycle any_valid, left-justified data, and bit-length len.
- Concatenates the variable-length records bit-contiguously into fixed OUT_WIDTH beats and buffers them in an output FIFO.
- The FIFO drains over a valid/ready interface to the trace-buffer writer.
- The upstream tree has no backpressure, so the block exports almful for the logb_almful pipeline. It also supports a flush that pads and emits a final partial beat.

Parameters:
- IN_WIDTH, 512, packed input data width; must satisfy IN_WIDTH <= OUT_WIDTH (elaboration $error otherwise).
- OUT_WIDTH, 512, output beat width.
- FIFO_DEPTH, 32, output FIFO entries; power of two, >= 4.
- ALMFUL_SLACK, 8, almful asserts when free entries <= ALMFUL_SLACK; must cover upstream pipeline depth.
- IN_LEN_W, $clog2(IN_WIDTH+1), width of in_len.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_any_valid  in  1  input record valid
- in_data  in  IN_WIDTH  record bits [in_len-1:0]; upper bits don't-care
- in_len  in  IN_LEN_W  valid bit count, 0..IN_WIDTH
- flush  in  1  level request: pad and emit residual bits
- flush_done  out  1  flush complete; held until flush deasserts
- out_valid  out  1  FIFO head valid
- out_data  out  OUT_WIDTH  FIFO head beat
- out_ready  in  1  consumer accepts head
- almful  out  1  registered almost-full
- overflow  out  1  sticky: data dropped
- beat_cnt  out  64  beats written into the FIFO since reset

Behaviour:
- Reset (async assert, sync deassert handled by the caller). All of the following are 0: out_valid, flush_done, almful, overflow, beat_cnt, accumulator fill, and FIFO pointers. FSM resets to IDLE.
- Accumulator:
  - acc is (OUT_WIDTH+IN_WIDTH) bits wide; fill is a count in 0..OUT_WIDTH-1 between cycles.
  - An accepted record writes in_data masked to in_len bits (bits >= in_len forced to 0) at acc[fill +: IN_WIDTH], then fill_n = fill + in_len.
- Beat emission:
  - If fill_n >= OUT_WIDTH, acc[OUT_WIDTH-1:0] is pushed into the FIFO on the same edge.
  - acc is then shifted right by OUT_WIDTH and fill = fill_n - OUT_WIDTH.
  - At most one beat per cycle (guaranteed by IN_WIDTH <= OUT_WIDTH).
- Zero-length record: in_any_valid=1 with in_len=0 is a no-op.
- Latency: a record completing a beat on edge N gives out_valid=1 after edge N, with the beat at out_data. FIFO is first-word-fall-through.
- FIFO:
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle is allowed at any occupancy, including full, where the pop frees a slot.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Full FIFO in IDLE with an emission needed and no simultaneous pop:
  - The beat is dropped and overflow is set sticky; beat_cnt is not incremented.
  - Residual bits are retained so alignment is preserved.
- almful: registered, next value = (FIFO_DEPTH - count_next) <= ALMFUL_SLACK.
- FSM:
  - IDLE:
    - Input is accepted normally.
    - flush=1 moves to PAD. Input in that same cycle is still accepted.
  - PAD:
    - Input is not accepted; in_any_valid=1 with in_len>0 sets overflow.
    - If fill==0, go to DRAIN.
    - Otherwise push acc[OUT_WIDTH-1:0] (zeros above fill) when the FIFO has room or a pop is occurring, set fill=0, and go to DRAIN. If the FIFO is full with no pop, stall in PAD; the beat is not dropped.
  - DRAIN: wait for FIFO empty, then go to DONE. Input rule is the same as PAD.
  - DONE: flush_done=1. Go to IDLE when flush=0.
- Dropping flush mid-PAD or mid-DRAIN does not abort; the sequence completes and DONE exits immediately.
- beat_cnt increments on every FIFO push, including padded beats, and wraps at 2^64.

Decomposition:
- Shared package rr_aligner_pkg:
  - FSM enum typedef (IDLE, PAD, DRAIN, DONE).
  - Default width constants.
  - A function that computes IN_LEN_W.
- Sub-module rr_beat_fifo:
  - Synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rstn, push, push_data, pop, head_valid, head_data, count, full.
  - The top level instantiates it once; the accumulator and FSM stay in the top level.

Test Plan (IN_WIDTH=16, OUT_WIDTH=16, FIFO_DEPTH=4, ALMFUL_SLACK=1 unless stated):
- Four records with len=4 and data 0x1, 0x2, 0x3, 0x4, out_ready=1 -> exactly one beat 0x4321 one cycle after the 4th record; beat_cnt=1.
- Records len=12 data 0xABC, then len=8 data 0xDE -> beat 0xEABC; fill=4. Flush -> padded beat 0x000D, flush_done=1 after the FIFO empties.
- out_ready=0 with 5 full-width records 0x1111..0x5555 -> almful=1 after the 3rd push; 5th beat dropped, overflow=1, beat_cnt=4. Release out_ready -> pops 0x1111..0x4444 in order.
- FIFO full, out_ready=0, fill=8, flush raised -> FSM holds in PAD with no drop. Raise out_ready -> padded beat emitted, then DRAIN, then DONE.
- in_any_valid=1 with len=0, then 16 cycles of idle -> no beats, fill unchanged, overflow=0. Assert rstn=0 mid-stream with the FIFO holding 2 beats -> out_valid=0 and beat_cnt=0 immediately, without waiting for a clock edge.
